// File: rtl/mmio_bridge_pkg.sv
// Shared MMIO address map, 7-segment patterns and polarity constants for mmio_bridge.
package mmio_bridge_pkg;

    localparam logic [31:0] MMIO_BASE  = 32'hFFFF_F000;
    localparam logic [31:0] MMIO_MASK  = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_SEG   = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_TIMER = 32'hFFFF_F020;
    localparam logic [31:0] ADDR_LED   = 32'hFFFF_F060;
    localparam logic [31:0] ADDR_SW    = 32'hFFFF_F070;

    // Board drives digits and segments active-low.
    localparam logic       SEG_ON        = 1'b0;
    localparam logic [7:0] DIG_EN_RESET  = 8'hFE;

    // {dp,g,f,e,d,c,b,a}, active-low, dp off; entry n is the glyph for hex n.
    localparam logic [15:0][7:0] SEG7_PAT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef enum logic [2:0] {
        SEL_DRAM, SEL_SEG, SEL_TIMER, SEL_LED, SEL_SW, SEL_NONE
    } sel_e;

    // Word-granular decode; any unlisted address in the MMIO page selects nothing.
    function automatic sel_e addr_decode(input logic [31:0] addr);
        logic [31:0] wa;
        wa = {addr[31:2], 2'b00};
        if ((wa & MMIO_MASK) != MMIO_BASE) return SEL_DRAM;
        case (wa)
            ADDR_SEG:   return SEL_SEG;
            ADDR_TIMER: return SEL_TIMER;
            ADDR_LED:   return SEL_LED;
            ADDR_SW:    return SEL_SW;
            default:    return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mmio_bridge_if.sv
// CPU data-port bus between the core (master) and mmio_bridge (slave).
interface mmio_bridge_if;
    logic [31:0] addr_from_cpu;
    logic [31:0] wdata_from_cpu;
    logic        we_from_cpu;
    logic [31:0] rdata_to_cpu;

    modport master (output addr_from_cpu, output wdata_from_cpu, output we_from_cpu,
                    input  rdata_to_cpu);
    modport slave  (input  addr_from_cpu, input  wdata_from_cpu, input  we_from_cpu,
                    output rdata_to_cpu);
endinterface

// File: rtl/mmio_bridge_seg7_decoder.sv
// Hex nibble to active-low 7-segment pattern, dp off; purely combinational.
module seg7_decoder
    import mmio_bridge_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] pattern
);
    assign pattern = SEG7_PAT[nibble];
endmodule

// File: rtl/mmio_bridge.sv
// Data-port responder: routes loads/stores to DRAM or LED/SW/7-seg/timer MMIO.
// Timer register is built only when MMIO_TIMER_EN is defined.
module mmio_bridge
    import mmio_bridge_pkg::*;
#(
    parameter int SCAN_DIV  = 20000,
    parameter int TIMER_DIV = 1,
    parameter int DRAM_AW   = 14
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    mmio_bridge_if.slave       bus,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic [31:0]        dram_wdata,
    output logic               dram_we,
    input  logic [31:0]        dram_rdata,
    input  logic [23:0]        sw,
    output logic [23:0]        led,
    output logic [7:0]         seg_en,
    output logic [7:0]         seg_dn
);
    localparam int SCW = $clog2(SCAN_DIV);

    sel_e        sel;
    logic        wr_seg, wr_led;
    logic [31:0] seg_reg;
    logic [23:0] sw_s1, sw_s2;
    logic [31:0] timer_val;

    assign sel    = addr_decode(bus.addr_from_cpu);
    assign wr_seg = bus.we_from_cpu && (sel == SEL_SEG);
    assign wr_led = bus.we_from_cpu && (sel == SEL_LED);

    assign dram_addr  = bus.addr_from_cpu[DRAM_AW+1:2];
    assign dram_wdata = bus.wdata_from_cpu;
    assign dram_we    = bus.we_from_cpu && (sel == SEL_DRAM);

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            led     <= '0;
            seg_reg <= '0;
            sw_s1   <= '0;
            sw_s2   <= '0;
        end else begin
            if (wr_led) led     <= bus.wdata_from_cpu[23:0];
            if (wr_seg) seg_reg <= bus.wdata_from_cpu;
            sw_s1 <= sw;
            sw_s2 <= sw_s1;
        end
    end

    // Scanner: outputs are registered from the current index, so a SEG write
    // shows on the lit digit from the edge after it lands.
    logic [SCW-1:0] scan_cnt;
    logic [2:0]     dig_idx;
    logic [7:0]     dig_pat;

    seg7_decoder u_dec (
        .nibble  (seg_reg[{dig_idx, 2'b00} +: 4]),
        .pattern (dig_pat)
    );

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
            seg_en   <= DIG_EN_RESET;
            seg_dn   <= SEG7_PAT[0];
        end else begin
            if (scan_cnt == SCW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                dig_idx  <= dig_idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            seg_en          <= '1;
            seg_en[dig_idx] <= SEG_ON;
            seg_dn          <= dig_pat;
        end
    end

`ifdef MMIO_TIMER_EN
    localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    logic [PW-1:0] presc;
    logic [31:0]   timer_q;
    logic          tick;

    assign tick      = (presc == PW'(TIMER_DIV - 1));
    assign timer_val = timer_q;

    // A CPU write wins over a coincident tick and restarts the prescaler.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            presc   <= '0;
            timer_q <= '0;
        end else if (bus.we_from_cpu && (sel == SEL_TIMER)) begin
            presc   <= '0;
            timer_q <= bus.wdata_from_cpu;
        end else if (tick) begin
            presc   <= '0;
            timer_q <= timer_q + 32'd1;
        end else begin
            presc   <= presc + 1'b1;
        end
    end
`else
    assign timer_val = '0;
`endif

    always_comb begin
        bus.rdata_to_cpu = '0;
        case (sel)
            SEL_DRAM:  bus.rdata_to_cpu = dram_rdata;
            SEL_SEG:   bus.rdata_to_cpu = seg_reg;
            SEL_TIMER: bus.rdata_to_cpu = timer_val;
            SEL_LED:   bus.rdata_to_cpu = {8'h00, led};
            SEL_SW:    bus.rdata_to_cpu = {8'h00, sw_s2};
            default:   bus.rdata_to_cpu = '0;
        endcase
    end

endmodule
